// File: rtl/led_sprite_pkg.sv
// Shared types and constants for the LED sprite overlay controller.
package led_sprite_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;
    localparam int RGB_W    = 16;
    localparam int COORD_W  = 10;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/led_sprite_pipe.sv
// Output stage: picks lit/unlit sprite word or background and registers the pixel.
// Macro LED_SPRITE_TRANSPARENT_EN makes ROM word 0 inside a sprite show the background.
module led_sprite_pipe
    import led_sprite_pkg::*;
#(
    parameter logic [RGB_W-1:0] BG_COLOR = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             act,
    input  logic             lit,
    input  logic             de,
    input  logic [RGB_W-1:0] on_dout,
    input  logic [RGB_W-1:0] off_dout,
    output logic [RGB_W-1:0] rgb,
    output logic             rgb_de
);

    logic [RGB_W-1:0] word;
    logic [RGB_W-1:0] rgb_d, rgb_q;
    logic             rgb_de_q;

    always_comb begin
        word  = lit ? on_dout : off_dout;
        rgb_d = BG_COLOR;
        if (!de) begin
            rgb_d = '0;
        end else if (act) begin
`ifdef LED_SPRITE_TRANSPARENT_EN
            rgb_d = (word == '0) ? BG_COLOR : word;
`else
            rgb_d = word;
`endif
        end
    end

    // stage 3: registered pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q    <= '0;
            rgb_de_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            rgb_de_q <= de;
        end
    end

    assign rgb    = rgb_q;
    assign rgb_de = rgb_de_q;

endmodule

// File: rtl/led_sprite_ctrl.sv
// Draws a row of on/off LED sprites from two shared-address ROMs over a VGA scan.
// Macro LED_SPRITE_TRANSPARENT_EN (see led_sprite_pipe) enables colour-key 0 transparency.
module led_sprite_ctrl
    import led_sprite_pkg::*;
#(
    parameter int               NUM_LEDS = 8,
    parameter int               X0       = 64,
    parameter int               Y0       = 224,
    parameter int               PITCH    = 40,
    parameter logic [RGB_W-1:0] BG_COLOR = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic                de,
    input  logic [NUM_LEDS-1:0] led_state,
    output logic [9:0]          rom_ad,
    output logic                rom_ce,
    output logic                rom_oce,
    input  logic [RGB_W-1:0]    rom_on_dout,
    input  logic [RGB_W-1:0]    rom_off_dout,
    output logic [RGB_W-1:0]    rgb,
    output logic                rgb_de
);

    localparam coord_t     X0_C     = coord_t'(X0);
    localparam coord_t     Y0_C     = coord_t'(Y0);
    localparam coord_t     Y1_C     = coord_t'(Y0 + SPRITE_H - 1);
    localparam logic [7:0] PITCH_M1 = 8'(PITCH - 1);
    localparam logic [7:0] SPR_LAST = 8'(SPRITE_W - 1);
    localparam logic [7:0] SPR_W8   = 8'(SPRITE_W);
    localparam logic [3:0] LAST_IDX = 4'(NUM_LEDS - 1);

    state_e                state_q, state_d;
    logic [7:0]            p_q, p_d;
    logic [3:0]            idx_q, idx_d, idx_cur;
    logic [4:0]            p_lo;
    logic [4:0]            row;
    logic                  start, act;
    logic [NUM_LEDS-1:0]   frame_q, frame_d;
    logic [15:0]           frame_ext;
    logic [9:0]            rom_ad_q, rom_ad_d;
    logic                  rom_ce_q, rom_ce_d;
    logic                  lit_p1_q, de_p1_q;
    logic                  act_p2_q, lit_p2_q, de_p2_q;

    assign start     = de && (x == X0_C) && (y >= Y0_C) && (y <= Y1_C);
    assign row       = 5'(y - Y0_C);
    assign frame_ext = 16'(frame_q);

    // The start pixel itself is sprite column 0, so p/idx act as 0 there and p resumes at 1.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        idx_d   = idx_q;
        p_lo    = p_q[4:0];
        idx_cur = idx_q;
        act     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    p_lo    = '0;
                    idx_cur = '0;
                    act     = 1'b1;
                    p_d     = 8'd1;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (!de) begin
                    state_d = ST_IDLE;
                    p_d     = '0;
                    idx_d   = '0;
                end else begin
                    act = (p_q < SPR_W8);
                    if ((idx_q == LAST_IDX) && (p_q == SPR_LAST)) begin
                        state_d = ST_IDLE;
                        p_d     = '0;
                        idx_d   = '0;
                    end else if (p_q == PITCH_M1) begin
                        p_d   = '0;
                        idx_d = idx_q + 4'd1;
                    end else begin
                        p_d = p_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rom_ce_d = act;
        rom_ad_d = act ? {row, p_lo} : rom_ad_q;
        frame_d  = ((x == '0) && (y == '0)) ? led_state : frame_q;
    end

    // stage 1: ROM address/enable plus control; stage 2 aligns control with ROM output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            rom_ad_q <= '0;
            rom_ce_q <= 1'b0;
            de_p1_q  <= 1'b0;
            act_p2_q <= 1'b0;
            de_p2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            rom_ad_q <= rom_ad_d;
            rom_ce_q <= rom_ce_d;
            de_p1_q  <= de;
            act_p2_q <= rom_ce_q;
            de_p2_q  <= de_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        lit_p1_q <= frame_ext[idx_cur];
        lit_p2_q <= lit_p1_q;
    end

    assign rom_ad  = rom_ad_q;
    assign rom_ce  = rom_ce_q;
    assign rom_oce = 1'b1;

    led_sprite_pipe #(
        .BG_COLOR (BG_COLOR)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .act      (act_p2_q),
        .lit      (lit_p2_q),
        .de       (de_p2_q),
        .on_dout  (rom_on_dout),
        .off_dout (rom_off_dout),
        .rgb      (rgb),
        .rgb_de   (rgb_de)
    );

endmodule

// File: tb/tb_led_sprite_ctrl.sv
// Scoreboard bench for led_sprite_ctrl: stimulus pushes expected pixels, a monitor pops them.
module tb_led_sprite_ctrl;

    localparam logic [15:0] BG = 16'hF800;
`ifdef LED_SPRITE_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        de;
    logic [7:0]  led_state;
    logic [9:0]  rom_ad;
    logic        rom_ce, rom_oce;
    logic [15:0] rom_on_dout = '0;
    logic [15:0] rom_off_dout = '0;
    logic [15:0] rgb;
    logic        rgb_de;

    typedef struct {
        logic [15:0] rgb;
        int          due;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         mon_en = 1'b0;
    bit         zp = 1'b0;
    logic [7:0] model_frame = '0;

    led_sprite_ctrl #(
        .BG_COLOR (BG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .de           (de),
        .led_state    (led_state),
        .rom_ad       (rom_ad),
        .rom_ce       (rom_ce),
        .rom_oce      (rom_oce),
        .rom_on_dout  (rom_on_dout),
        .rom_off_dout (rom_off_dout),
        .rgb          (rgb),
        .rgb_de       (rgb_de)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [15:0] rom_word(input bit on, input int ad);
        if (zp && (ad % 32) == 0) return 16'h0000;
        return on ? (16'hA000 | 16'(ad)) : (16'h5000 | 16'(ad));
    endfunction

    always @(posedge clk) begin
        if (rom_ce) begin
            rom_on_dout  <= rom_word(1'b1, int'(rom_ad));
            rom_off_dout <= rom_word(1'b0, int'(rom_ad));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rgb_de) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rgb_de_unexpected: got rgb_de=1 rgb=%0h expected no pixel (cycle %0d)", rgb, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rgb", 32'(rgb), 32'(e.rgb));
                    chk("latency", cyc, e.due);
                end
            end else begin
                chk("rgb_blank_zero", 32'(rgb), 32'h0);
            end
        end
    end

    task automatic frame_start();
        @(posedge clk); #1;
        x = '0; y = '0; de = 1'b1;
        model_frame = led_state;
        q.push_back('{rgb: BG, due: cyc + 3});
        @(posedge clk); #1;
        de = 1'b0;
    endtask

    task automatic run_line(input int yy, input int stop_x);
        bit          run, dd, cur_act, prev_ce;
        int          rel, pp, ii, ad, prev_ad;
        logic [15:0] w, e;
        run = 0; prev_ce = 0; prev_ad = 0;
        for (int xx = 0; xx < 400; xx++) begin
            dd = (xx < stop_x);
            @(posedge clk); #1;
            x = 10'(xx); y = 10'(yy); de = dd;
            cur_act = 0; ad = 0; e = BG;
            if (!dd) run = 0;
            else if (xx == 64 && yy >= 224 && yy <= 255) run = 1;
            if (run) begin
                rel = xx - 64;
                pp  = rel % 40;
                ii  = rel / 40;
                if (pp < 32 && ii < 8) begin
                    cur_act = 1;
                    ad = (yy - 224) * 32 + pp;
                    w  = rom_word(model_frame[ii], ad);
                    e  = (w == 16'h0000) ? (TRANSP ? BG : 16'h0000) : w;
                end
            end
            if (dd) q.push_back('{rgb: e, due: cyc + 3});
            @(negedge clk);
            chk("rom_ce", 32'(rom_ce), 32'(prev_ce));
            if (prev_ce) chk("rom_ad", 32'(rom_ad), prev_ad);
            prev_ce = cur_act;
            prev_ad = ad;
        end
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            de = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; x = '0; y = '0; de = 1'b0; led_state = '0;
        @(posedge clk); #1;
        x = 10'd64; y = 10'd224; de = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mon_en = 1'b1;
            @(negedge clk);
            chk("reset_rom_ce", 32'(rom_ce), 32'h0);
            chk("reset_rgb", 32'(rgb), 32'h0);
            chk("reset_rgb_de", 32'(rgb_de), 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_frame = '0;
        q.push_back('{rgb: 16'h5000, due: cyc + 3});
        @(posedge clk); #1;
        de = 1'b0;
        @(negedge clk);
        chk("run_after_release", 32'(rom_ce), 32'h1);
        repeat (6) @(posedge clk);

        led_state = 8'b0000_0001;
        frame_start();
        run_line(230, 1024);
        run_line(223, 1024);
        run_line(256, 1024);
        run_line(230, 120);
        run_line(231, 1024);

        led_state = 8'hFF;
        frame_start();
        run_line(230, 1024);
        led_state = 8'h00;
        run_line(231, 1024);
        frame_start();
        run_line(230, 1024);

        zp = 1'b1;
        run_line(230, 1024);
        zp = 1'b0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_sprite_ctrl.md
LED_SPRITE_CTRL -- requirements
Module: led_sprite_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of LED sprites drawn in a row (1..16).
REQ-002 SHALL have parameter X0, default 64, x of first sprite's left column.
REQ-003 SHALL have parameter Y0, default 224, y of sprite band's top line.
REQ-004 SHALL have parameter PITCH, default 40, horizontal distance in pixels between sprite origins (32..255).
REQ-005 SHALL have parameter BG_COLOR, default 16'h0000, RGB565 colour outside sprites.
REQ-006 SHALL have port clk  input  1  pixel clock, sole clock.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports x, y  input  10 each  current pixel coordinates from VGA timing; de  input  1  active video.
REQ-009 SHALL have port led_state  input  NUM_LEDS  bit i high selects the lit sprite for LED i.
REQ-010 SHALL have ports rom_ad  output  10  shared address to on/off sprite ROMs; rom_ce  output  1  ROM read enable; rom_oce  output  1  tied high.
REQ-011 SHALL have ports rom_on_dout, rom_off_dout  input  16 each  ROM data, valid one clk after rom_ad/rom_ce.
REQ-012 SHALL have ports rgb  output  16  RGB565 pixel; rgb_de  output  1  de delayed to match rgb.

Function
REQ-013 SHALL run a 2-state FSM: IDLE, RUN.
REQ-014 IDLE->RUN SHALL occur when de=1, x==X0 and Y0<=y<=Y0+31; col, pitch counter p and LED index idx load 0 at that cycle.
REQ-015 In RUN, p SHALL increment each cycle; when p==PITCH-1, p->0 and idx increments.
REQ-016 RUN->IDLE SHALL occur when idx==NUM_LEDS-1 and p==31, or immediately when de=0 (mid-line abort).
REQ-017 Sprite-active SHALL be RUN and p<32; rom_ad={y-Y0 [4:0], p[4:0]}, rom_ce=sprite-active, both registered (rom_ad holds last value when rom_ce=0).
REQ-018 Pipeline: stage 1 registers rom_ad/rom_ce/idx/de; stage 2 is the ROM; stage 3 registers rgb and rgb_de; total latency x,y,de -> rgb/rgb_de SHALL be 3 clk.
REQ-019 rgb SHALL be rom_on_dout when the delayed sprite-active is set and latched led_state[idx]=1, rom_off_dout when set and bit=0, BG_COLOR otherwise; rgb SHALL be 16'h0000 when delayed de=0.
REQ-020 led_state SHALL be latched into an internal frame copy only at x==0, y==0 (any de), so LED changes never tear mid-frame.
REQ-021 PITCH<32 or NUM_LEDS*PITCH overrunning x=1023 is unsupported; no wrap handling required.

Reset
REQ-022 On reset: FSM=IDLE, p=0, idx=0, rom_ad=0, rom_ce=0, rgb=16'h0000, rgb_de=0, latched led_state=0, all pipeline valids 0.
REQ-023 Reset asserted mid-sprite SHALL take effect on the next clk edge; first valid rgb follows 3 clk after reset release.

Configuration
REQ-024 Macro LED_SPRITE_TRANSPARENT_EN defined: ROM word 16'h0000 inside a sprite SHALL output BG_COLOR.
REQ-025 Macro LED_SPRITE_TRANSPARENT_EN undefined: ROM word 16'h0000 SHALL output as 16'h0000 (black).

Structure
REQ-026 Shared package SHALL hold: FSM state enum, SPRITE_W=32, SPRITE_H=32, RGB565 width constant, 10-bit coordinate typedef.
REQ-027 One sub-module SHALL exist: led_sprite_pipe (stage-3 colour select/transparency mux); FSM and counters stay in the top.

Verification
REQ-028 Reset with de=1, x=X0, y=Y0 -> rom_ce=0, rgb=0, rgb_de=0 throughout reset; FSM enters RUN only after release.
REQ-029 Defaults, led_state=8'b0000_0001 latched, line y=230 -> at x=64 rom_ad=10'd192 next clk, rgb=rom_on_dout 3 clk after x=64, LED 1 (x=104) shows rom_off_dout, x=96..103 give BG_COLOR.
REQ-030 Line y=223 and y=256 -> rom_ce never asserts, rgb=BG_COLOR wherever rgb_de=1.
REQ-031 de drops at x=120 inside LED 1 -> FSM IDLE next clk, rom_ce=0, rgb_de falls 3 clk later; next line restarts at idx=0.
REQ-032 led_state changed 8'hFF->8'h00 at y=230 mid-frame -> current frame unchanged; new value used after x=0,y=0.
REQ-033 With LED_SPRITE_TRANSPARENT_EN, BG_COLOR=16'hF800, ROM word 0 at p=0 -> rgb=16'hF800; without macro -> rgb=16'h0000.
